axis_rand_sink: RTL
===================

// Module: axis_rand_sink
// PURPOSE
// - Randomised AXI-Stream sink. Consumes the per-cycle rand64 word from the xoshiro PRNG and turns it into tready backpressure.
// - Backpressure is a random ready/stall pattern with a programmable stall probability and a bounded random stall length.
// - Counts accepted beats, packets and bytes, and flags framing errors. Used as the terminating stage in example/test designs.
// PARAMETERS
// - DATA_WIDTH    512  tdata width in bits; a multiple of 8; tkeep is DATA_WIDTH/8.
// - STALL_THRESH  64   0..256. Each READY cycle enters STALL when rand64[7:0] < STALL_THRESH (0 = never, 256 = always).
// - STALL_MASK    8'h0F  mask applied to rand64[15:8]; stall length = (rand64[15:8] & STALL_MASK) + 1 cycles.
// - CNT_WIDTH     32   width of beat/packet counters; byte counter is CNT_WIDTH+8.
// PORTS
// - clk             in   1            single clock, all logic rising-edge
// - rst             in   1            synchronous, active-high reset
// - enable          in   1            0 forces IDLE (tready=0)
// - rand64          in   64           PRNG output, new value every cycle
// - s_axis_tdata    in   DATA_WIDTH   ignored except for width
// - s_axis_tkeep    in   DATA_WIDTH/8 byte enables
// - s_axis_tlast    in   1            end of packet
// - s_axis_tvalid   in   1            upstream valid
// - s_axis_tready   out  1            registered ready
// - beat_cnt        out  CNT_WIDTH    accepted beats, wraps
// - pkt_cnt         out  CNT_WIDTH    accepted tlast beats, wraps
// - byte_cnt        out  CNT_WIDTH+8  sum of popcount(tkeep), wraps
// - err_sticky      out  1            framing error seen, cleared only by rst
// BEHAVIOUR
// - Reset: state=IDLE; tready=0; all counters=0; err_sticky=0; stall_cnt=0.
// - Handshake hs = tvalid & tready (tready is the registered output).
// - FSM, evaluated every cycle (a low enable overrides everything):
//   IDLE:  enable=1 -> READY; tready<=1 next cycle.
//   READY: tready=1. If rand64[7:0] < STALL_THRESH -> STALL, with stall_cnt <= rand64[15:8] & STALL_MASK and tready<=0. Otherwise stay in READY.
//   STALL: tready=0. stall_cnt==0 -> READY (tready<=1); otherwise stall_cnt--.
//   Resulting stall length is exactly (field & STALL_MASK)+1 cycles of tready=0.
//   enable=0 in any state -> IDLE and tready<=0 the next cycle. A beat handshaked in that same cycle is still counted.
// - Ready may drop while tvalid=1 (legal for a slave). The sink never depends on tvalid to raise tready.
// - Counter pipeline (latency 1 cycle):
//   - hs in cycle N: beat_cnt+1, pkt_cnt+tlast, byte_cnt+popcount(tkeep), all visible at cycle N+1.
//   - Counters wrap modulo 2^width, with no saturation.
// - Framing errors: on hs, set err_sticky at N+1 if either of these holds:
//   - tlast=0 and tkeep != all-ones (partial mid-packet beat);
//   - tlast=1 and tkeep == 0 (empty last beat).
// - rst mid-packet or mid-stall: the next cycle is identical to the post-reset state. Partial-packet state is discarded.
// - rand64 bits [63:16] are unused.
// STRUCTURE
// - Package axis_rand_pkg: state_t enum {IDLE, READY, STALL}; localparams RAND_THR_LSB=0, RAND_LEN_LSB=8, RAND_FIELD_W=8.
// - One sub-module: keep_popcount (pure combinational, parameter KEEP_W, out width $clog2(KEEP_W)+1). Its result is registered here with hs.
// - Top level instantiates xoshiro128ss_simple alongside this block and wires rand64 through. This block holds no PRNG of its own.
// TESTING (rand64 driven directly by the bench unless noted)
// - Reset: hold rst 3 cycles with tvalid=1 -> tready=0 and all counters=0 throughout; enable=1 -> tready=1 two cycles after rst falls.
// - STALL_THRESH=0, tvalid=1 constant, 100 beats with tkeep all-ones, tlast every 4th -> tready stays 1; beat_cnt=100, pkt_cnt=25, byte_cnt=6400 (DATA_WIDTH=512).
// - rand64=64'h0000_0000_0000_0300 (thr byte 0x00, len 0x03) for one cycle in READY, then 64'hFF -> tready low exactly 4 cycles, then high.
// - Mid-packet beat with tkeep=64'h0000_FFFF, tlast=0 -> err_sticky=1 next cycle and stays 1 until rst; byte_cnt increments by 16.
// - enable dropped during STALL with stall_cnt=5 -> IDLE, tready=0; re-enable -> READY with no residual stall.
// - Wrap: CNT_WIDTH=4, 17 single-beat packets -> beat_cnt=1, pkt_cnt=1; the beat counted in the cycle rst asserts is lost, with counters=0.

Source files
------------

// File: rtl/axis_rand_sink_pkg.sv
// Shared types and field positions for the randomised AXI-Stream sink.
// The PRNG word layout is fixed here so the sink and its users agree.
package axis_rand_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    STALL
  } state_t;

  localparam int RAND_THR_LSB = 0;
  localparam int RAND_LEN_LSB = 8;
  localparam int RAND_FIELD_W = 8;

endpackage

// File: rtl/axis_rand_sink_if.sv
// AXI-Stream bundle between an upstream source and the random sink.
// tready is the only signal driven by the slave side.
interface axis_rand_sink_if #(
  parameter int DATA_WIDTH = 512
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_W-1:0]     tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_rand_sink_popcount.sv
// Combinational count of set byte-enable bits.
// Result is wide enough to hold KEEP_W itself.
module keep_popcount #(
  parameter int KEEP_W = 64
) (
  input  logic [KEEP_W-1:0]         keep,
  output logic [$clog2(KEEP_W):0]   count
);

  localparam int CW = $clog2(KEEP_W) + 1;

  // sum the enable bits one at a time
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      count = count + CW'(keep[i]);
    end
  end

endmodule

// File: rtl/axis_rand_sink.sv
// Random-backpressure AXI-Stream sink with beat/packet/byte counters.
// rand64 comes from an external PRNG; no randomness is generated here.
module axis_rand_sink
  import axis_rand_pkg::*;
#(
  parameter int         DATA_WIDTH   = 512,
  parameter int         STALL_THRESH = 64,
  parameter logic [7:0] STALL_MASK   = 8'h0F,
  parameter int         CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [63:0]          rand64,
  axis_rand_sink_if.slave      s_axis,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH+7:0] byte_cnt,
  output logic                 err_sticky
);

  localparam int         KEEP_W = DATA_WIDTH / 8;
  localparam int         PC_W   = $clog2(KEEP_W) + 1;
  localparam int         BYTE_W = CNT_WIDTH + 8;
  localparam logic [8:0] THR    = 9'(STALL_THRESH);

  state_t                  state;
  state_t                  state_n;
  logic                    tready;
  logic                    tready_n;
  logic [RAND_FIELD_W-1:0] stall_cnt;
  logic [RAND_FIELD_W-1:0] stall_n;
  logic [RAND_FIELD_W-1:0] thr_field;
  logic [RAND_FIELD_W-1:0] len_field;
  logic                    thr_hit;
  logic                    hs;
  logic                    keep_full;
  logic                    keep_none;
  logic                    frame_bad;
  logic [PC_W-1:0]         pc;
  logic                    unused_bits;

  assign thr_field = rand64[RAND_THR_LSB +: RAND_FIELD_W];
  assign len_field = rand64[RAND_LEN_LSB +: RAND_FIELD_W];
  assign thr_hit   = {1'b0, thr_field} < THR;

  assign s_axis.tready = tready;
  assign hs            = s_axis.tvalid & tready;

  assign keep_full = &s_axis.tkeep;
  assign keep_none = ~|s_axis.tkeep;
  assign frame_bad = s_axis.tlast ? keep_none : ~keep_full;

  assign unused_bits = ^{s_axis.tdata, rand64[63:16]};

  keep_popcount #(
    .KEEP_W (KEEP_W)
  ) u_pc (
    .keep  (s_axis.tkeep),
    .count (pc)
  );

  // FSM state, registered ready and stall down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tready    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      tready    <= tready_n;
      stall_cnt <= stall_n;
    end
  end

  // next state; a low enable parks the sink in IDLE
  always_comb begin
    state_n  = state;
    tready_n = 1'b0;
    stall_n  = stall_cnt;
    if (!enable) begin
      state_n = IDLE;
      stall_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n  = READY;
          tready_n = 1'b1;
        end
        READY: begin
          if (thr_hit) begin
            state_n = STALL;
            stall_n = len_field & STALL_MASK;
          end else begin
            tready_n = 1'b1;
          end
        end
        STALL: begin
          if (stall_cnt == '0) begin
            state_n  = READY;
            tready_n = 1'b1;
          end else begin
            stall_n = stall_cnt - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          stall_n = '0;
        end
      endcase
    end
  end

  // traffic counters, updated the cycle after a handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
      byte_cnt <= '0;
    end else if (hs) begin
      beat_cnt <= beat_cnt + 1'b1;
      pkt_cnt  <= pkt_cnt + CNT_WIDTH'(s_axis.tlast);
      byte_cnt <= byte_cnt + BYTE_W'(pc);
    end
  end

  // framing error latch, only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (hs && frame_bad) begin
      err_sticky <= 1'b1;
    end
  end

endmodule
